multiword_add_sequencer: RTL and testbench

//   Byte-serial multi-precision unsigned adder controller. Accepts two WORDS*8-bit

---
 rtl/multiword_add_sequencer.sv | 99 +++++++++
 tb/tb_multiword_add_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Byte-serial multi-precision unsigned adder: one 8-bit add-with-carry slice per cycle,
// LSB byte first, with a valid/ready request and result handshake.
module multiword_add_sequencer #(
    parameter int unsigned Words = 4,
    localparam int unsigned W    = 8 * Words,
    localparam int unsigned IdxW = (Words > 1) ? $clog2(Words) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_valid_i,
    output logic         start_ready_o,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    input  logic         cin_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] result_o,
    output logic         cout_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;

    logic [7:0]      a_byte, b_byte;
    logic [8:0]      sum;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;

        a_byte  = a_q[8*int'(idx_q) +: 8];
        b_byte  = b_q[8*int'(idx_q) +: 8];
        sum     = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};

        unique case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[8*int'(idx_q) +: 8] = sum[7:0];
                carry_d                   = sum[8];
                if (idx_q == IdxW'(Words - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // All outputs come straight from registers; no input-to-output combinational path.
    assign start_ready_o = (state_q == StIdle);
    assign res_valid_o   = (state_q == StDone);
    assign busy_o        = (state_q != StIdle);
    assign result_o      = res_q;
    assign cout_o        = carry_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: a 4-byte instance and a 1-byte instance
// sharing one clock, checked against hand-computed sums and a simple A+B+CIN model.
module tb_multiword_add_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sv4 = 0, rr4 = 0, ci4 = 0;
    logic [31:0] a4 = 0, b4 = 0;
    logic        sr4, rv4, co4, busy4;
    logic [31:0] res4;

    logic        sv1 = 0, rr1 = 0, ci1 = 0;
    logic [7:0]  a1 = 0, b1 = 0;
    logic        sr1, rv1, co1, busy1;
    logic [7:0]  res1;

    int n_vec = 0;
    int n_err = 0;

    multiword_add_sequencer #(.Words(4)) u_dut4 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (sv4),
        .start_ready_o (sr4),
        .op_a_i        (a4),
        .op_b_i        (b4),
        .cin_i         (ci4),
        .res_valid_o   (rv4),
        .res_ready_i   (rr4),
        .result_o      (res4),
        .cout_o        (co4),
        .busy_o        (busy4)
    );

    multiword_add_sequencer #(.Words(1)) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (sv1),
        .start_ready_o (sr1),
        .op_a_i        (a1),
        .op_b_i        (b1),
        .cin_i         (ci1),
        .res_valid_o   (rv1),
        .res_ready_i   (rr1),
        .result_o      (res1),
        .cout_o        (co1),
        .busy_o        (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; operands are scrambled right after accept to prove sampling.
    task automatic run_req(input bit one, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic [31:0] exp_r, input logic exp_c,
                           input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ".start_ready"}, one ? sr1 : sr4, 1);
        if (one) begin
            sv1 = 1; a1 = a[7:0]; b1 = b[7:0]; ci1 = ci;
        end else begin
            sv4 = 1; a4 = a; b4 = b; ci4 = ci;
        end
        @(negedge clk);
        sv1 = 0; sv4 = 0;
        a4 = ~a; b4 = ~b; ci4 = ~ci;
        a1 = ~a[7:0]; b1 = ~b[7:0]; ci1 = ~ci;
        lat = 0;
        while ((one ? rv1 : rv4) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, one ? {24'b0, res1} : res4, exp_r);
        check({tag, ".cout"}, one ? co1 : co4, exp_c);
        rr1 = one; rr4 = !one;
        @(negedge clk);
        rr1 = 0; rr4 = 0;
        check({tag, ".idle"}, one ? busy1 : busy4, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] model;

        #3;
        check("rst.start_ready4", sr4, 1);
        check("rst.res_valid4", rv4, 0);
        check("rst.result4", res4, 0);
        check("rst.cout4", co4, 0);
        check("rst.busy4", busy4, 0);
        check("rst.start_ready1", sr1, 1);
        check("rst.result1", res1, 0);
        #9 rst_n = 1;

        run_req(0, 32'h0000_00FF, 32'h0000_0001, 0, 32'h0000_0100, 0, 4, "t1");
        run_req(0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'h0000_0000, 1, 4, "t2");
        run_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 4, "t3");
        run_req(0, 32'h89AB_CDEF, 32'h7654_3210, 1, 32'h0000_0000, 1, 4, "t3b");
        run_req(0, 32'h0102_0304, 32'h1020_3040, 0, 32'h1122_3344, 0, 4, "t3c");

        // Backpressure: result held, new requests ignored while DONE.
        @(negedge clk);
        sv4 = 1; a4 = 32'h0000_1234; b4 = 32'h0000_4321; ci4 = 0;
        @(negedge clk);
        sv4 = 0;
        for (int i = 0; i < 20 && rv4 !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sv4 = i[0]; a4 = $urandom;
            @(negedge clk);
            check("t4.result", res4, 32'h0000_5555);
            check("t4.cout", co4, 0);
            check("t4.start_ready", sr4, 0);
            check("t4.res_valid", rv4, 1);
        end
        sv4 = 0; rr4 = 1;
        @(negedge clk);
        rr4 = 0;
        check("t4.back_idle", sr4, 1);
        check("t4.valid_drop", rv4, 0);
        @(negedge clk);
        check("t4.no_new_op", busy4, 0);

        // Reset aborts an operation in progress at idx 2.
        sv4 = 1; a4 = 32'hAAAA_AAAA; b4 = 32'h5555_5555; ci4 = 1;
        @(negedge clk);
        sv4 = 0;
        @(negedge clk);
        @(negedge clk);
        check("t5.busy_before", busy4, 1);
        #1 rst_n = 0;
        #1;
        check("t5.start_ready", sr4, 1);
        check("t5.res_valid", rv4, 0);
        check("t5.busy", busy4, 0);
        check("t5.result", res4, 0);
        check("t5.cout", co4, 0);
        #1 rst_n = 1;
        run_req(0, 32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 4, "t5.after");

        // Single-byte instance.
        run_req(1, 32'h80, 32'h80, 1, 32'h01, 1, 1, "t6");
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            run_req(1, {24'b0, ra}, {24'b0, rb}, rc, {24'b0, model[7:0]}, model[8], 1, "t6.rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
